chiplib_arb_pri_age: RTL and testbench

- Priority-aging front end placed directly upstream of the priority arbiter (`chiplib_arb_pri`).
- Each requestor presents a base priority. The block raises that priority by one level for every AgeThreshold consecutive cycles the requestor waits without a grant. This prevents starvation of low-priority requestors.
- Outputs `arb_req`/`arb_pri` feed the arbiter's req/req_pri. The arbiter's gnt returns on `arb_gnt` and drives the per-requestor boost state.

---
 rtl/chiplib_arb_pri_age.sv | 78 +++++++
 tb/tb_chiplib_arb_pri_age.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/chiplib_arb_pri_age.sv
// rtl/chiplib_arb_pri_age.sv - priority-aging front end for the priority arbiter
module chiplib_arb_pri_age #(
  parameter  int NumReq        = 10,
  parameter  int NumPriorities = 5,
  parameter  int AgeThreshold  = 8,
  localparam int PriorityWidth = $clog2(NumPriorities),
  localparam int AgeWidth      = $clog2(AgeThreshold) + 1
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  age_en,
  input  logic [NumReq-1:0]                     in_req,
  input  logic [NumReq-1:0][PriorityWidth-1:0]  in_pri,
  output logic [NumReq-1:0]                     arb_req,
  output logic [NumReq-1:0][PriorityWidth-1:0]  arb_pri,
  input  logic [NumReq-1:0]                     arb_gnt,
  output logic [NumReq-1:0]                     gnt,
  output logic [NumReq-1:0]                     boosted
);

  localparam logic [PriorityWidth-1:0] MaxPri  = PriorityWidth'(NumPriorities - 1);
  localparam logic [AgeWidth-1:0]      AgeLast = AgeWidth'(AgeThreshold - 1);

  logic [NumReq-1:0][AgeWidth-1:0]      age_q, age_d;
  logic [NumReq-1:0][PriorityWidth-1:0] boost_q, boost_d;

  // Passthrough request; grants to idle requestors are dropped.
  assign arb_req = in_req;
  assign gnt     = arb_gnt & in_req;

  // Effective priority: clamped base plus boost, saturating at the top level.
  always_comb begin
    logic [PriorityWidth-1:0] base;
    logic [PriorityWidth:0]   sum;
    arb_pri = '0;
    boosted = '0;
    base    = '0;
    sum     = '0;
    for (int j = 0; j < NumReq; j++) begin
      base = (in_pri[j] > MaxPri) ? MaxPri : in_pri[j];
      sum  = {1'b0, base} + {1'b0, boost_q[j]};
      arb_pri[j] = (sum > {1'b0, MaxPri}) ? MaxPri : sum[PriorityWidth-1:0];
      boosted[j] = (boost_q[j] != '0);
    end
  end

  // Next age/boost: idle or granted clears, then enable gate, then threshold roll-over.
  always_comb begin
    age_d   = age_q;
    boost_d = boost_q;
    for (int j = 0; j < NumReq; j++) begin
      if (!in_req[j] || arb_gnt[j]) begin
        age_d[j]   = '0;
        boost_d[j] = '0;
      end else if (!age_en) begin
        age_d[j]   = age_q[j];
        boost_d[j] = boost_q[j];
      end else if (age_q[j] == AgeLast) begin
        age_d[j]   = '0;
        boost_d[j] = (boost_q[j] >= MaxPri) ? boost_q[j] : boost_q[j] + PriorityWidth'(1);
      end else begin
        age_d[j]   = age_q[j] + AgeWidth'(1);
      end
    end
  end

  // Per-requestor wait state, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      age_q   <= '0;
      boost_q <= '0;
    end else begin
      age_q   <= age_d;
      boost_q <= boost_d;
    end
  end

endmodule

// File: tb/tb_chiplib_arb_pri_age.sv
// tb/tb_chiplib_arb_pri_age.sv - self-checking bench for chiplib_arb_pri_age
module tb_chiplib_arb_pri_age;

  localparam int NR = 10;
  localparam int NP = 5;
  localparam int TH = 8;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 age_en;
  logic [NR-1:0]        in_req;
  logic [NR-1:0][2:0]   in_pri;
  logic [NR-1:0]        arb_req;
  logic [NR-1:0][2:0]   arb_pri;
  logic [NR-1:0]        arb_gnt;
  logic [NR-1:0]        gnt;
  logic [NR-1:0]        boosted;

  int n_checks = 0;
  int n_fail   = 0;

  int m_age   [NR];
  int m_boost [NR];

  chiplib_arb_pri_age #(.NumReq(NR), .NumPriorities(NP), .AgeThreshold(TH)) dut (
    .clk     (clk),
    .rst     (rst),
    .age_en  (age_en),
    .in_req  (in_req),
    .in_pri  (in_pri),
    .arb_req (arb_req),
    .arb_pri (arb_pri),
    .arb_gnt (arb_gnt),
    .gnt     (gnt),
    .boosted (boosted)
  );

  always #5 clk = ~clk;

  function automatic int exp_pri(int j);
    int b;
    b = int'(in_pri[j]);
    if (b > NP - 1) b = NP - 1;
    b = b + m_boost[j];
    if (b > NP - 1) b = NP - 1;
    return b;
  endfunction

  task automatic model_clear();
    for (int j = 0; j < NR; j++) begin
      m_age[j]   = 0;
      m_boost[j] = 0;
    end
  endtask

  // Advance one clock edge and apply the waiting-time rules to the model.
  task automatic tick();
    @(posedge clk);
    for (int j = 0; j < NR; j++) begin
      if (rst || !in_req[j] || arb_gnt[j]) begin
        m_age[j] = 0; m_boost[j] = 0;
      end else if (age_en) begin
        m_age[j] = m_age[j] + 1;
        if (m_age[j] == TH) begin
          m_age[j] = 0;
          if (m_boost[j] < NP - 1) m_boost[j] = m_boost[j] + 1;
        end
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_req = '0; in_pri = '0; arb_gnt = '0; age_en = 1'b1;
    model_clear();
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    in_req = 10'h3FF;
    for (int j = 0; j < NR; j++) in_pri[j] = 3'(j % 8);
    arb_gnt = 10'h004;
    rst = 1'b1;
    #2;
    n_checks++;
    if (boosted !== '0) begin n_fail++; $display("FAIL reset_boosted got=%h exp=0", boosted); end
    n_checks++;
    if (arb_req !== in_req) begin n_fail++; $display("FAIL reset_arb_req got=%h exp=%h", arb_req, in_req); end
    n_checks++;
    if (gnt !== 10'h004) begin n_fail++; $display("FAIL reset_gnt got=%h exp=004", gnt); end
    for (int j = 0; j < NR; j++) begin
      n_checks++;
      if (int'(arb_pri[j]) != ((j % 8) > 4 ? 4 : (j % 8))) begin
        n_fail++; $display("FAIL reset_arb_pri[%0d] got=%0d", j, arb_pri[j]);
      end
    end
    tick();
    do_reset();
  endtask

  task automatic test_aging_basic();
    do_reset();
    in_req[3] = 1'b1; in_pri[3] = 3'd1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      n_checks++;
      if (int'(arb_pri[3]) != ((c < 24) ? 1 + c / 8 : 4)) begin
        n_fail++; $display("FAIL aging_pri cyc=%0d got=%0d exp=%0d", c, arb_pri[3], (c < 24) ? 1 + c / 8 : 4);
      end
      n_checks++;
      if (boosted[3] !== (c >= 8)) begin
        n_fail++; $display("FAIL aging_boosted cyc=%0d got=%b exp=%b", c, boosted[3], c >= 8);
      end
      tick();
    end
  endtask

  task automatic test_grant_clear();
    do_reset();
    in_req[3] = 1'b1; in_pri[3] = 3'd1;
    for (int c = 0; c < 23; c++) begin
      arb_gnt[3] = (c == 12);
      @(negedge clk);
      if (c == 12) begin
        n_checks++;
        if (gnt[3] !== 1'b1) begin n_fail++; $display("FAIL grant_gnt got=%b exp=1", gnt[3]); end
        n_checks++;
        if (arb_pri[3] !== 3'd2) begin n_fail++; $display("FAIL grant_pri12 got=%0d exp=2", arb_pri[3]); end
      end
      if (c == 13 || c == 20) begin
        n_checks++;
        if (arb_pri[3] !== 3'd1 || boosted[3] !== 1'b0) begin
          n_fail++; $display("FAIL grant_cleared cyc=%0d pri=%0d boosted=%b exp pri=1 boosted=0", c, arb_pri[3], boosted[3]);
        end
      end
      if (c == 21 || c == 22) begin
        n_checks++;
        if (arb_pri[3] !== 3'd2 || boosted[3] !== 1'b1) begin
          n_fail++; $display("FAIL grant_reboost cyc=%0d pri=%0d boosted=%b exp pri=2 boosted=1", c, arb_pri[3], boosted[3]);
        end
      end
      tick();
    end
    arb_gnt = '0;
  endtask

  task automatic test_saturate_mixed();
    do_reset();
    in_req[0] = 1'b1; in_pri[0] = 3'd4;
    in_req[5] = 1'b1; in_pri[5] = 3'd0;
    for (int c = 0; c < 42; c++) begin
      @(negedge clk);
      n_checks++;
      if (arb_pri[0] !== 3'd4) begin n_fail++; $display("FAIL sat_top cyc=%0d got=%0d exp=4", c, arb_pri[0]); end
      n_checks++;
      if (int'(arb_pri[5]) != ((c / 8 > 4) ? 4 : c / 8)) begin
        n_fail++; $display("FAIL sat_low cyc=%0d got=%0d exp=%0d", c, arb_pri[5], (c / 8 > 4) ? 4 : c / 8);
      end
      tick();
    end
  endtask

  task automatic test_age_en_hold();
    do_reset();
    in_req[2] = 1'b1; in_pri[2] = 3'd0;
    for (int c = 0; c < 16; c++) begin
      age_en = !(c >= 4 && c <= 9);
      @(negedge clk);
      n_checks++;
      if (int'(arb_pri[2]) != ((c >= 14) ? 1 : 0)) begin
        n_fail++; $display("FAIL age_en_hold cyc=%0d got=%0d exp=%0d", c, arb_pri[2], (c >= 14) ? 1 : 0);
      end
      tick();
    end
    age_en = 1'b1;
  endtask

  task automatic test_req_drop();
    do_reset();
    in_req[6] = 1'b1; in_pri[6] = 3'd0;
    arb_gnt[7] = 1'b1;
    for (int c = 0; c < 21; c++) begin
      in_req[6] = (c != 10);
      @(negedge clk);
      n_checks++;
      if (int'(arb_pri[6]) != ((c >= 8 && c <= 10) || c >= 19 ? 1 : 0)) begin
        n_fail++; $display("FAIL req_drop cyc=%0d got=%0d exp=%0d", c, arb_pri[6], ((c >= 8 && c <= 10) || c >= 19) ? 1 : 0);
      end
      if (c == 10) begin
        n_checks++;
        if (arb_req !== in_req) begin n_fail++; $display("FAIL drop_arb_req got=%h exp=%h", arb_req, in_req); end
      end
      n_checks++;
      if (gnt[7] !== 1'b0) begin n_fail++; $display("FAIL stray_gnt cyc=%0d got=%b exp=0", c, gnt[7]); end
      tick();
    end
    arb_gnt = '0;
  endtask

  task automatic test_async_reset_clamp();
    do_reset();
    in_req[1] = 1'b1; in_pri[1] = 3'd0;
    in_req[4] = 1'b1; in_pri[4] = 3'd2;
    for (int c = 0; c < 20; c++) tick();
    n_checks++;
    if (boosted[1] !== 1'b1 || arb_pri[4] !== 3'd4) begin
      n_fail++; $display("FAIL pre_reset boosted1=%b pri4=%0d exp boosted1=1 pri4=4", boosted[1], arb_pri[4]);
    end
    #2;
    rst = 1'b1;
    model_clear();
    #1;
    n_checks++;
    if (boosted !== '0) begin n_fail++; $display("FAIL async_rst_boosted got=%h exp=0", boosted); end
    n_checks++;
    if (arb_pri[1] !== 3'd0 || arb_pri[4] !== 3'd2) begin
      n_fail++; $display("FAIL async_rst_pri got=%0d,%0d exp=0,2", arb_pri[1], arb_pri[4]);
    end
    in_pri[8] = 3'd7;
    #1;
    n_checks++;
    if (arb_pri[8] !== 3'd4) begin n_fail++; $display("FAIL clamp_pri got=%0d exp=4", arb_pri[8]); end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      for (int j = 0; j < NR; j++) begin
        in_req[j] = ($urandom_range(0, 15) != 0);
        if ($urandom_range(0, 31) == 0) in_pri[j] = 3'($urandom_range(0, 7));
      end
      arb_gnt = ($urandom_range(0, 5) == 0) ? (10'd1 << $urandom_range(0, NR - 1)) : '0;
      age_en  = ($urandom_range(0, 9) != 0);
      @(negedge clk);
      n_checks++;
      if (arb_req !== in_req) begin n_fail++; $display("FAIL rnd_arb_req cyc=%0d got=%h exp=%h", c, arb_req, in_req); end
      n_checks++;
      if (gnt !== (arb_gnt & in_req)) begin n_fail++; $display("FAIL rnd_gnt cyc=%0d got=%h exp=%h", c, gnt, arb_gnt & in_req); end
      for (int j = 0; j < NR; j++) begin
        n_checks++;
        if (int'(arb_pri[j]) != exp_pri(j) || boosted[j] !== (m_boost[j] != 0)) begin
          n_fail++;
          $display("FAIL rnd_pri cyc=%0d req=%0d pri=%0d boosted=%b exp pri=%0d boosted=%b",
                   c, j, arb_pri[j], boosted[j], exp_pri(j), m_boost[j] != 0);
        end
      end
      tick();
    end
  endtask

  initial begin
    rst = 1'b1; age_en = 1'b1; in_req = '0; in_pri = '0; arb_gnt = '0;
    model_clear();
    test_reset();
    test_aging_basic();
    test_grant_clear();
    test_saturate_mixed();
    test_age_en_hold();
    test_req_drop();
    test_async_reset_clamp();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
